waybit_array: RTL
=================

Name: waybit_array

Overview:
- Parametrised per-set way-bit store (valid/dirty/LRU-style flags) for the L1 tag pipeline: one bit per way per set.
- One write port with per-way or all-way update.
- One registered read port with write-first bypass.
- Hardware init/flush sweep that clears every entry after reset or on request, with a busy indication so the pipeline stalls.

Parameters:
- ENTRIES, 8192, number of sets (any value ≥ 2; need not be a power of 2).
- AW, $clog2(ENTRIES) = 13, set-address width.
- WAYS, 4, ways per set; bit width of one entry.
- INIT_VAL, 1'b0, value written to every bit by the init/flush sweep.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- re  input  1  read enable.
- ra  input  AW  read set address.
- rd  output  WAYS  registered read data, bit i = way i.
- wr  input  1  write enable.
- wa  input  AW  write set address.
- way_sel  input  WAYS  one-hot way select for single-way write.
- wr_all  input  1  with wr: write `in` into all ways of set wa (way_sel ignored).
- in  input  1  bit value to write.
- flush  input  1  single-cycle request: start a clear sweep.
- busy  output  1  sweep in progress; writes dropped, reads return init pattern.
- wr_err  output  1  one-cycle pulse: illegal write request dropped.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - While reset = 1: rd = 0, wr_err = 0, busy = 1, sweep counter = 0, FSM = SWEEP.
  - Array contents are not cleared by reset itself; the sweep clears them.
- Sweep FSM, states IDLE and SWEEP:
  - SWEEP: each cycle writes {WAYS{INIT_VAL}} to entry cnt, then cnt++. The cycle that writes entry ENTRIES-1 sets the FSM to IDLE, so busy = 0 on the following cycle.
  - After reset deasserts, busy stays high for exactly ENTRIES cycles.
  - IDLE + flush = 1: next cycle FSM = SWEEP, cnt = 0, busy = 1. Same ENTRIES-cycle duration.
  - flush while busy: ignored; the sweep neither restarts nor extends.
  - reset mid-sweep: cnt returns to 0 and the sweep restarts after reset deasserts.
- Reads:
  - re = 1 at edge N → rd updated at edge N+1 (latency 1).
  - re = 0 → rd holds its previous value.
  - ra ≥ ENTRIES → rd = 0.
  - While busy (or on the edge where a sweep is writing), re = 1 loads rd = {WAYS{INIT_VAL}}.
- Writes (only when busy = 0):
  - Single-cycle read-modify-write, committed at the edge where wr = 1.
  - wr_all = 1: entry[wa] = {WAYS{in}}.
  - wr_all = 0 and way_sel one-hot: only bit index(way_sel) of entry[wa] is replaced with `in`; all other bits are preserved.
- Illegal writes, all dropped with no array change:
  - wr_all = 0 and way_sel zero or multi-hot → wr_err = 1 for one cycle.
  - wa ≥ ENTRIES → wr_err = 1 for one cycle.
  - wr = 1 while busy → no wr_err (expected stall case).
- Simultaneous events:
  - re and wr in the same cycle with ra == wa and the write legal: rd shows the post-write value (write-first bypass).
  - Back-to-back writes to the same set, different ways: both persist, because the second RMW sees the first.
- No combinational path from any input to rd, busy or wr_err; all outputs are registered.

Decomposition:
- Shared package cache_pkg holds:
  - default ENTRIES/WAYS localparams;
  - the sweep-state enum {IDLE, SWEEP};
  - a function onehot_ok(mask) returning 1 when exactly one bit is set.
- Sub-module waybit_sweep_ctl contains the FSM, the AW-bit counter and busy generation. It outputs sweep_we and sweep_addr.
- The storage array, RMW merge, bypass and error logic stay in waybit_array.

Test Plan:
- Reset for 3 cycles, release → busy high for exactly 8192 cycles; then re at ra = 0x1FFF → rd = 4'b0000.
- Idle, wr = 1, wa = 0x005, way_sel = 4'b0100, in = 1; next cycle wr, way_sel = 4'b0001, in = 1; then re at 0x005 → rd = 4'b0101.
- Same cycle wr_all = 1, in = 1, wa = 0x0A0 and re with ra = 0x0A0 → rd = 4'b1111 on the next edge.
- wr with way_sel = 4'b0110 at wa = 0x010 → wr_err pulses exactly 1 cycle; a later read of 0x010 is unchanged (4'b0000).
- Set several entries, pulse flush; pulse flush again 100 cycles later → busy lasts exactly 8192 cycles from the first flush; writes during busy are dropped with no wr_err; all entries read 4'b0000 afterwards.
- Assert reset at sweep count 4000 for 1 cycle → busy lasts 8192 more cycles after release. With ENTRIES = 6, WAYS = 8: write wa = 6 → wr_err = 1; read ra = 7 → rd = 8'h00.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the L1 tag-pipeline way-bit stores: default geometry,
// sweep FSM state encoding and a one-hot mask check.
package cache_pkg;

    localparam int DEF_ENTRIES = 8192;
    localparam int DEF_WAYS    = 4;
    localparam int MAX_WAYS    = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } sweep_state_e;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic onehot_ok(input logic [MAX_WAYS-1:0] mask);
        return (mask != '0) && ((mask & (mask - MAX_WAYS'(1))) == '0);
    endfunction

endpackage

// File: rtl/waybit_sweep_ctl.sv
// Init/flush sweep controller: walks every set once after reset or on a flush
// request, presenting one clear-write per cycle and holding busy meanwhile.
module waybit_sweep_ctl
    import cache_pkg::*;
#(
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int AW      = $clog2(ENTRIES)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          flush_i,
    output logic          busy_o,
    output logic          sweep_we_o,
    output logic [AW-1:0] sweep_addr_o
);

    localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);

    sweep_state_e  state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush only starts a sweep from IDLE, so a request while busy neither
    // restarts nor extends the current pass.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        sweep_we_o   = (state_q == SWEEP);
        busy_o       = (state_q == SWEEP);
        sweep_addr_o = cnt_q;
    end

endmodule

// File: rtl/waybit_array.sv
// Per-set way-bit store (valid/dirty/LRU flags): one RMW write port, one
// registered write-first read port, and a hardware clear sweep.
module waybit_array
    import cache_pkg::*;
#(
    parameter int   ENTRIES  = DEF_ENTRIES,
    parameter int   AW       = $clog2(ENTRIES),
    parameter int   WAYS     = DEF_WAYS,
    parameter logic INIT_VAL = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            re,
    input  logic [AW-1:0]   ra,
    output logic [WAYS-1:0] rd,
    input  logic            wr,
    input  logic [AW-1:0]   wa,
    input  logic [WAYS-1:0] way_sel,
    input  logic            wr_all,
    input  logic            in,
    input  logic            flush,
    output logic            busy,
    output logic            wr_err
);

    localparam logic [AW:0]     ENTRIES_W = (AW + 1)'(ENTRIES);
    localparam logic [WAYS-1:0] INIT_PAT  = {WAYS{INIT_VAL}};

    logic            sweep_we;
    logic [AW-1:0]   sweep_addr;
    logic            sweep_busy;

    logic [WAYS-1:0] mem_q [ENTRIES];

    logic            wa_ok;
    logic            ra_ok;
    logic            mask_ok;
    logic            wr_ok;
    logic [WAYS-1:0] wr_old;
    logic [WAYS-1:0] wr_new;
    logic [WAYS-1:0] rd_d, rd_q;
    logic            wr_err_d, wr_err_q;

    waybit_sweep_ctl #(
        .ENTRIES (ENTRIES),
        .AW      (AW)
    ) u_sweep_ctl (
        .clk_i        (clk),
        .reset_i      (reset),
        .flush_i      (flush),
        .busy_o       (sweep_busy),
        .sweep_we_o   (sweep_we),
        .sweep_addr_o (sweep_addr)
    );

    // Write path: single-cycle read-modify-write of the addressed set.
    always_comb begin
        wa_ok    = ({1'b0, wa} < ENTRIES_W);
        ra_ok    = ({1'b0, ra} < ENTRIES_W);
        mask_ok  = wr_all | onehot_ok(MAX_WAYS'(way_sel));
        wr_old   = wa_ok ? mem_q[wa] : '0;
        wr_new   = wr_all ? {WAYS{in}}
                          : ((wr_old & ~way_sel) | (way_sel & {WAYS{in}}));
        // Writes during a sweep are the normal stall case and stay silent.
        wr_ok    = wr & !reset & !sweep_we & wa_ok & mask_ok;
        wr_err_d = wr & !reset & !sweep_we & !(wa_ok & mask_ok);
    end

    // Read path: sweep pattern wins, then range check, then same-set bypass.
    always_comb begin
        rd_d = rd_q;
        if (re) begin
            if (sweep_we) begin
                rd_d = INIT_PAT;
            end else if (!ra_ok) begin
                rd_d = '0;
            end else if (wr_ok && (ra == wa)) begin
                rd_d = wr_new;
            end else begin
                rd_d = mem_q[ra];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem_q[sweep_addr] <= INIT_PAT;
        end else if (wr_ok) begin
            mem_q[wa] <= wr_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q     <= '0;
            wr_err_q <= 1'b0;
        end else begin
            rd_q     <= rd_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign rd     = rd_q;
    assign wr_err = wr_err_q;
    assign busy   = sweep_busy;

endmodule
